// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_decoder
// Description : Recovers the value shown on a multiplexed, active-low 8-digit
//               7-segment display by watching its digit-select and segment
//               lines. Each digit is captured once its select and segment
//               lines have been stable for SETTLE_CYC cycles. The captured
//               pattern is decoded to a hex nibble, and a frame pulse is
//               raised once all eight digits have been refreshed.
//
// Ports       : clk         - system clock
//               rst         - asynchronous active-high reset
//               sel[7:0]    - digit select, active-low (sel[i]=0 -> digit i)
//               seg[7:0]    - segments, active-low (a..g = [0..6], dp = [7])
//               digits[31:0]- captured hex value, digit i at [4i+3:4i]
//               dp[7:0]     - captured decimal point per digit (1 = lit)
//               blank[7:0]  - digit captured with a..g all off
//               bad[7:0]    - digit captured with an unrecognised a..g pattern
//               frame_valid - one-cycle pulse when all 8 digits are refreshed
//               sel_err     - sticky: more than one digit selected at once
//               stall       - scan watchdog timeout
//
// Options     : SCAN_WATCHDOG_EN - when defined, stall rises after
//               TIMEOUT_CYC cycles without a frame_valid. When undefined,
//               stall is tied low and no watchdog counter exists.
//
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_decoder #(
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  sel,
    input  logic [7:0]  seg,
    output logic [31:0] digits,
    output logic [7:0]  dp,
    output logic [7:0]  blank,
    output logic [7:0]  bad,
    output logic        frame_valid,
    output logic        sel_err,
    output logic        stall
);

    localparam int                 c_CNT_W   = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [7:0]         r_sel, r_seg;
    logic [7:0]         r_cur_sel, r_cur_seg;
    logic [2:0]         r_idx, w_sel_idx;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [7:0]         r_mask, w_mask_nxt;
    logic               r_sel_err;
    logic [31:0]        r_digits;
    logic [7:0]         r_dp, r_blank, r_bad;
    logic               w_cur_ld, w_capture;
    logic [7:0]         w_sel_n;
    logic               w_idle, w_one_hot, w_illegal, w_fv;
    logic [5:0]         w_dec;

    // Returns {bad, blank, value} for an active-high a..g pattern.
    function automatic logic [5:0] decode_glyph(input logic [6:0] on);
        logic [5:0] r;
        case (on)
            7'h3F:   r = {2'b00, 4'h0};
            7'h06:   r = {2'b00, 4'h1};
            7'h5B:   r = {2'b00, 4'h2};
            7'h4F:   r = {2'b00, 4'h3};
            7'h66:   r = {2'b00, 4'h4};
            7'h6D:   r = {2'b00, 4'h5};
            7'h7D:   r = {2'b00, 4'h6};
            7'h07:   r = {2'b00, 4'h7};
            7'h7F:   r = {2'b00, 4'h8};
            7'h6F:   r = {2'b00, 4'h9};
            7'h77:   r = {2'b00, 4'hA};
            7'h7C:   r = {2'b00, 4'hB};
            7'h39:   r = {2'b00, 4'hC};
            7'h5E:   r = {2'b00, 4'hD};
            7'h79:   r = {2'b00, 4'hE};
            7'h71:   r = {2'b00, 4'hF};
            7'h00:   r = {2'b01, 4'h0};
            default: r = {2'b10, 4'h0};
        endcase
        return r;
    endfunction

    // Select classification works on the active-high form: legal means
    // nothing selected or exactly one bit set.
    assign w_sel_n   = ~r_sel;
    assign w_idle    = (w_sel_n == 8'h00);
    assign w_one_hot = !w_idle && ((w_sel_n & (w_sel_n - 8'd1)) == 8'h00);
    assign w_illegal = !w_idle && !w_one_hot;
    assign w_fv      = (r_mask == 8'hFF);
    assign w_dec     = decode_glyph(~r_cur_seg[6:0]);

    always_comb begin
        w_sel_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!r_sel[i]) w_sel_idx = 3'(i);
        end
    end

    // Next-state logic. w_cur_ld snapshots the current sel/seg as the
    // reference that later cycles are compared against.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cur_ld    = 1'b0;
        w_capture   = 1'b0;
        if (w_illegal || w_idle) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_cur_ld    = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_sel != r_cur_sel || r_seg != r_cur_seg) begin
                        w_cur_ld  = 1'b1;
                        w_cnt_nxt = '0;
                    end else if (r_cnt == c_CNT_MAX) begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    // Segment changes are ignored until a new digit is selected.
                    if (r_sel != r_cur_sel) begin
                        w_cur_ld    = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_SETTLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // A clear (frame done or illegal select) is applied before the capture
    // bit so a coincident capture is never lost.
    always_comb begin
        w_mask_nxt = (w_fv || w_illegal) ? 8'h00 : r_mask;
        if (w_capture) w_mask_nxt[r_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel     <= 8'hFF;
            r_seg     <= 8'hFF;
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_cur_sel <= 8'hFF;
            r_cur_seg <= 8'hFF;
            r_idx     <= 3'd0;
            r_mask    <= 8'h00;
            r_sel_err <= 1'b0;
            r_digits  <= 32'h0;
            r_dp      <= 8'h00;
            r_blank   <= 8'h00;
            r_bad     <= 8'h00;
        end else begin
            r_sel   <= sel;
            r_seg   <= seg;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mask  <= w_mask_nxt;
            if (w_cur_ld) begin
                r_cur_sel <= r_sel;
                r_cur_seg <= r_seg;
                r_idx     <= w_sel_idx;
            end
            if (w_illegal)
                r_sel_err <= 1'b1;
            else if (w_fv)
                r_sel_err <= 1'b0;
            if (w_capture) begin
                r_digits[4*r_idx +: 4] <= w_dec[3:0];
                r_blank[r_idx]         <= w_dec[4];
                r_bad[r_idx]           <= w_dec[5];
                r_dp[r_idx]            <= ~r_cur_seg[7];
            end
        end
    end

`ifdef SCAN_WATCHDOG_EN
    localparam int             c_WD_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_WD_W-1:0] c_WD_MAX = c_WD_W'(TIMEOUT_CYC);

    logic [c_WD_W-1:0] r_wd_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_wd_cnt <= '0;
        else if (w_fv)
            r_wd_cnt <= '0;
        else if (r_wd_cnt != c_WD_MAX)
            r_wd_cnt <= r_wd_cnt + 1'b1;
    end

    assign stall = (r_wd_cnt == c_WD_MAX);
`else
    // Watchdog compiled out: stall is constant low for any valid TIMEOUT_CYC.
    assign stall = (TIMEOUT_CYC < 0);
`endif

    assign digits      = r_digits;
    assign dp          = r_dp;
    assign blank       = r_blank;
    assign bad         = r_bad;
    assign frame_valid = w_fv;
    assign sel_err     = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_decoder
// Description : Self-checking bench for seg_scan_decoder. A reference model
//               based on "visits" (runs of one selected digit) predicts every
//               output each cycle. Directed sequences and a glyph table cover
//               the corner cases, and random scans cover the rest.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_decoder;

    localparam int S  = 16;
    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  sel, seg;
    logic [31:0] digits;
    logic [7:0]  dp, blank, bad;
    logic        frame_valid, sel_err, stall;

    always #5 clk = ~clk;

    seg_scan_decoder #(.SETTLE_CYC(S), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .sel(sel), .seg(seg),
        .digits(digits), .dp(dp), .blank(blank), .bad(bad),
        .frame_valid(frame_valid), .sel_err(sel_err), .stall(stall)
    );

    int errors = 0;
    int checks = 0;
    int fv_seen = 0;

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // ---------------- reference model ----------------
    logic [7:0]  m_rsel, m_rseg;           // input as seen one cycle late
    logic [31:0] m_digits;
    logic [7:0]  m_dp, m_blank, m_bad, m_mask;
    bit          m_err;
    int          m_wd;
    bit          m_vis, m_capd;
    logic [7:0]  m_vsel, m_vseg;
    int          m_run;

    task automatic model_reset();
        m_rsel = 8'hFF; m_rseg = 8'hFF;
        m_digits = 0; m_dp = 0; m_blank = 0; m_bad = 0; m_mask = 0;
        m_err = 0; m_wd = 0; m_vis = 0; m_capd = 0; m_run = 0;
        m_vsel = 8'hFF; m_vseg = 8'hFF;
    endtask

    // Advance the model across one clock edge, then latch the new inputs.
    task automatic model_step();
        int  zeros;
        bit  fv, ill, cap, found;
        int  idx;
        logic [6:0] on;
        zeros = $countones(~m_rsel);
        fv    = (m_mask == 8'hFF);
        ill   = 0; cap = 0; idx = 0;
        if (zeros > 1) begin
            ill = 1; m_vis = 0;
        end else if (zeros == 0) begin
            m_vis = 0;
        end else begin
            if (!m_vis || m_rsel != m_vsel) begin
                m_vis = 1; m_vsel = m_rsel; m_vseg = m_rseg; m_run = 1; m_capd = 0;
            end else if (m_rseg == m_vseg) begin
                m_run++;
            end else begin
                m_vseg = m_rseg; m_run = 1;
            end
            if (!m_capd && m_run == S + 1) begin
                cap = 1; m_capd = 1;
            end
        end
        if (cap) begin
            for (int i = 0; i < 8; i++) if (!m_rsel[i]) idx = i;
            on = ~m_rseg[6:0];
            found = 0;
            m_digits[idx*4 +: 4] = 4'h0;
            for (int v = 0; v < 16; v++) begin
                if (glyph[v] == on) begin
                    m_digits[idx*4 +: 4] = 4'(v); found = 1;
                end
            end
            m_blank[idx] = (on == 7'h00);
            m_bad[idx]   = !found && (on != 7'h00);
            m_dp[idx]    = ~m_rseg[7];
        end
        if (fv || ill) m_mask = 8'h00;
        if (cap) m_mask[idx] = 1'b1;
        if (ill) m_err = 1;
        else if (fv) m_err = 0;
        if (fv) m_wd = 0;
        else if (m_wd < TO) m_wd++;
        m_rsel = sel; m_rseg = seg;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic exp_stall;
`ifdef SCAN_WATCHDOG_EN
        exp_stall = (m_wd == TO);
`else
        exp_stall = 1'b0;
`endif
        chk("digits", digits, m_digits);
        chk("dp", {24'h0, dp}, {24'h0, m_dp});
        chk("blank", {24'h0, blank}, {24'h0, m_blank});
        chk("bad", {24'h0, bad}, {24'h0, m_bad});
        chk("frame_valid", {31'h0, frame_valid}, {31'h0, m_mask == 8'hFF});
        chk("sel_err", {31'h0, sel_err}, {31'h0, m_err});
        chk("stall", {31'h0, stall}, {31'h0, exp_stall});
    endtask

    task automatic step_and_check();
        model_step();
        @(posedge clk);
        #1;
        if (frame_valid === 1'b1) fv_seen++;
        compare_all();
    endtask

    task automatic tick(input logic [7:0] s, input logic [7:0] g);
        @(negedge clk);
        sel = s; seg = g;
        step_and_check();
    endtask

    task automatic visit(input int d, input logic [7:0] g, input int n);
        for (int k = 0; k < n; k++) tick(~(8'd1 << d), g);
    endtask

    function automatic logic [7:0] seg_for(input int v, input bit dp_on);
        logic [6:0] gl;
        gl = glyph[v];
        return {~dp_on, ~gl};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        chk("reset_digits_zero", digits, 32'h0);
        @(posedge clk);
        @(negedge clk);
        sel = 8'hFF; seg = 8'hFF;
        rst = 1'b0;
        step_and_check();
    endtask

    typedef struct packed {
        logic [7:0] seg;
        logic [3:0] val;
        logic       blank;
        logic       bad;
        logic       dp;
    } vec_t;

    vec_t tv [12];

    initial begin
        int d, a, b, n, r;
        logic [7:0] s, g;
        rst = 1'b1; sel = 8'hFF; seg = 8'hFF;
        model_reset();

        tv[0]  = '{8'hC0, 4'h0, 1'b0, 1'b0, 1'b0};
        tv[1]  = '{8'h40, 4'h0, 1'b0, 1'b0, 1'b1};
        tv[2]  = '{8'h88, 4'hA, 1'b0, 1'b0, 1'b0};
        tv[3]  = '{8'h03, 4'hB, 1'b0, 1'b0, 1'b1};
        tv[4]  = '{8'hC6, 4'hC, 1'b0, 1'b0, 1'b0};
        tv[5]  = '{8'hA1, 4'hD, 1'b0, 1'b0, 1'b0};
        tv[6]  = '{8'h86, 4'hE, 1'b0, 1'b0, 1'b0};
        tv[7]  = '{8'h0E, 4'hF, 1'b0, 1'b0, 1'b1};
        tv[8]  = '{8'h90, 4'h9, 1'b0, 1'b0, 1'b0};
        tv[9]  = '{8'h80, 4'h8, 1'b0, 1'b0, 1'b0};
        tv[10] = '{8'hFF, 4'h0, 1'b1, 1'b0, 1'b0};
        tv[11] = '{8'hFE, 4'h0, 1'b0, 1'b1, 1'b0};

        repeat (2) @(posedge clk);
        do_reset();

        // Full "12345678" frame
        fv_seen = 0;
        for (int i = 0; i < 8; i++) visit(i, seg_for(i + 1, 1'b0), 20);
        repeat (3) tick(8'hFF, 8'hFF);
        chk("frame_count_full_scan", fv_seen, 1);
        chk("frame_digits", digits, 32'h87654321);
        chk("frame_dp_blank_bad", {8'h0, dp, blank, bad}, 32'h0);

        // Glyph table
        for (int i = 0; i < 12; i++) begin
            visit(i % 8, tv[i].seg, 20);
            chk("tbl_val", {28'h0, digits[(i%8)*4 +: 4]}, {28'h0, tv[i].val});
            chk("tbl_blank", {31'h0, blank[i%8]}, {31'h0, tv[i].blank});
            chk("tbl_bad", {31'h0, bad[i%8]}, {31'h0, tv[i].bad});
            chk("tbl_dp", {31'h0, dp[i%8]}, {31'h0, tv[i].dp});
        end

        // Short visit to digit 3 is not captured
        do_reset();
        fv_seen = 0;
        for (int i = 0; i < 8; i++) visit(i, seg_for(i + 1, 1'b0), (i == 3) ? 10 : 20);
        repeat (3) tick(8'hFF, 8'hFF);
        chk("short_visit_no_frame", fv_seen, 0);
        chk("short_visit_no_digit3", {28'h0, digits[15:12]}, 32'h0);
        visit(3, seg_for(4, 1'b0), 20);
        chk("late_visit_frame", fv_seen, 1);
        chk("late_visit_digit3", {28'h0, digits[15:12]}, 32'h4);

        // Illegal select mid-scan
        do_reset();
        fv_seen = 0;
        for (int i = 0; i < 4; i++) visit(i, seg_for(i, 1'b0), 20);
        tick(8'b11110011, 8'hC0);
        tick(8'b11110011, 8'hC0);
        chk("illegal_sets_err", {31'h0, sel_err}, 32'h1);
        for (int i = 4; i < 8; i++) visit(i, seg_for(i, 1'b0), 20);
        chk("illegal_cleared_mask", fv_seen, 0);
        for (int i = 0; i < 8; i++) visit(i, seg_for(i, 1'b0), 20);
        chk("recover_frame", fv_seen, 1);
        chk("recover_err_clear", {31'h0, sel_err}, 32'h0);

        // Blank and unrecognised patterns
        do_reset();
        visit(0, 8'hFF, 20);
        visit(1, 8'b0_1010101, 20);
        chk("blank0", {31'h0, blank[0]}, 32'h1);
        chk("bad1", {31'h0, bad[1]}, 32'h1);
        chk("dp1", {31'h0, dp[1]}, 32'h1);
        chk("bad0_blank1", {30'h0, bad[0], blank[1]}, 32'h0);

        // Reset during SETTLE of digit 5
        for (int i = 0; i < 5; i++) visit(i, seg_for(i + 2, 1'b1), 20);
        visit(5, seg_for(7, 1'b1), 8);
        do_reset();
        visit(5, seg_for(7, 1'b1), 10);
        chk("post_reset_no_capture", {digits[23:0], dp}, 32'h0);

        // Random scans
        do_reset();
        for (int v = 0; v < 300; v++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                a = $urandom_range(0, 7);
                b = (a + 1 + $urandom_range(0, 6)) % 8;
                s = ~((8'd1 << a) | (8'd1 << b));
            end else if (r == 1) begin
                s = 8'hFF;
            end else begin
                d = $urandom_range(0, 7);
                s = ~(8'd1 << d);
            end
            r = $urandom_range(0, 3);
            if (r < 2) g = seg_for($urandom_range(0, 15), 1'($urandom_range(0, 1)));
            else if (r == 2) g = 8'($urandom);
            else g = 8'hFF;
            n = $urandom_range(1, 24);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 15) == 0) g = 8'($urandom);
                tick(s, g);
            end
        end

        // Watchdog
        do_reset();
`ifdef SCAN_WATCHDOG_EN
        repeat (TO - 2) tick(8'hFF, 8'hFF);
        chk("wd_before_timeout", {31'h0, stall}, 32'h0);
        repeat (2) tick(8'hFF, 8'hFF);
        chk("wd_timeout", {31'h0, stall}, 32'h1);
        fv_seen = 0;
        for (int i = 0; i < 8; i++) visit(i, seg_for(i, 1'b0), 20);
        chk("wd_frame", fv_seen, 1);
        chk("wd_cleared", {31'h0, stall}, 32'h0);
`else
        repeat (TO + 50) tick(8'hFF, 8'hFF);
        chk("stall_tied_low", {31'h0, stall}, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
